// File: rtl/arm_pkg.sv
// Shared architectural constants for the NZCV status flags and condition codes.
// Flag order everywhere is {N,Z,C,V}.
package arm_pkg;

  localparam int NZCV_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // AL and the 1111 encoding never look at the flags, so they can never stall on them.
  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return (cond != COND_AL) && (cond != COND_NV);
  endfunction

endpackage

// File: rtl/status_flag_unit.sv
// Architectural NZCV register with write-once commit under EXE stall,
// same-cycle forwarding to ID (BYPASS=1) or a flag hazard (BYPASS=0).
module status_flag_unit
  import arm_pkg::*;
#(
  parameter int                 BYPASS      = 1,
  parameter logic [NZCV_W-1:0]  RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_s,
  input  logic [NZCV_W-1:0] exe_alu_flags,
  input  logic              exe_hold,
  input  logic [3:0]        id_cond,
  output logic [NZCV_W-1:0] status_out,
  output logic [NZCV_W-1:0] status_reg,
  output logic              flag_hazard,
  output logic              flags_written
);

  localparam bit BYPASS_EN = (BYPASS != 0);

  logic done_reg;
  logic commit;

  // A held instruction commits only on its first cycle; done_reg blocks replays.
  assign commit = exe_valid & exe_s & ~done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg    <= RESET_FLAGS;
      done_reg      <= 1'b0;
      flags_written <= 1'b0;
    end else begin
      if (commit) begin
        status_reg <= exe_alu_flags;
      end
      done_reg      <= exe_hold & (done_reg | commit);
      flags_written <= commit;
    end
  end

  always_comb begin
    status_out  = status_reg;
    flag_hazard = 1'b0;
    if (BYPASS_EN) begin
      if (commit) begin
        status_out = exe_alu_flags;
      end
    end else begin
      flag_hazard = commit & cond_uses_flags(id_cond);
    end
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Table-driven bench for status_flag_unit: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_status_flag_unit;

  logic       clk;
  logic       rst;
  logic       exe_valid;
  logic       exe_s;
  logic [3:0] exe_alu_flags;
  logic       exe_hold;
  logic [3:0] id_cond;

  logic [3:0] status_out_b, status_reg_b;
  logic       flag_hazard_b, flags_written_b;
  logic [3:0] status_out_n, status_reg_n;
  logic       flag_hazard_n, flags_written_n;

  status_flag_unit #(.BYPASS(1), .RESET_FLAGS(4'b0000)) dut_b (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .exe_alu_flags(exe_alu_flags), .exe_hold(exe_hold), .id_cond(id_cond),
    .status_out(status_out_b), .status_reg(status_reg_b),
    .flag_hazard(flag_hazard_b), .flags_written(flags_written_b)
  );

  status_flag_unit #(.BYPASS(0), .RESET_FLAGS(4'b0000)) dut_n (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s(exe_s),
    .exe_alu_flags(exe_alu_flags), .exe_hold(exe_hold), .id_cond(id_cond),
    .status_out(status_out_n), .status_reg(status_reg_n),
    .flag_hazard(flag_hazard_n), .flags_written(flags_written_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic [3:0] f;
    logic       h;
    logic [3:0] cond;
    logic       chk;
    logic [3:0] out_b;
    logic [3:0] out_n;
    logic       hz;
    logic [3:0] sr;
    logic       fw;
  } vec_t;

  typedef struct {
    logic       chk;
    logic [3:0] out_b;
    logic [3:0] out_n;
    logic       hz;
    logic [3:0] sr;
    logic       fw;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];
  exp_t exp_q[$];

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act === req) begin
      passed++;
    end else begin
      $display("FAIL %s vec=%0d got=%b required=%b", name, idx, act, req);
    end
  endtask

  task automatic set_vec(input int i, input logic r, input logic v, input logic s, input logic [3:0] f,
                         input logic h, input logic [3:0] cond, input logic chk,
                         input logic [3:0] out_b, input logic [3:0] out_n, input logic hz,
                         input logic [3:0] sr, input logic fw);
    vecs[i] = '{rst: r, v: v, s: s, f: f, h: h, cond: cond, chk: chk,
                out_b: out_b, out_n: out_n, hz: hz, sr: sr, fw: fw};
  endtask

  initial begin
    exp_t e;
    int   pulses;

    rst = 1'b1; exe_valid = 1'b0; exe_s = 1'b0; exe_alu_flags = 4'h0; exe_hold = 1'b0; id_cond = 4'hE;

    //          rst  v    s    flags    hold cond     chk  out_b    out_n    hz   sr       fw
    set_vec( 0, 1'b1,1'b0,1'b0,4'b0000,1'b0,4'b1110,1'b0,4'b0000,4'b0000,1'b0,4'b0000,1'b0);
    set_vec( 1, 1'b0,1'b1,1'b1,4'b0110,1'b0,4'b0000,1'b1,4'b0110,4'b0000,1'b1,4'b0110,1'b1);
    set_vec( 2, 1'b0,1'b1,1'b0,4'b1111,1'b0,4'b0000,1'b1,4'b0110,4'b0110,1'b0,4'b0110,1'b0);
    set_vec( 3, 1'b0,1'b1,1'b1,4'b0010,1'b1,4'b0000,1'b1,4'b0010,4'b0110,1'b1,4'b0010,1'b1);
    set_vec( 4, 1'b0,1'b1,1'b1,4'b1000,1'b1,4'b0000,1'b1,4'b0010,4'b0010,1'b0,4'b0010,1'b0);
    set_vec( 5, 1'b0,1'b1,1'b1,4'b1000,1'b1,4'b0000,1'b1,4'b0010,4'b0010,1'b0,4'b0010,1'b0);
    set_vec( 6, 1'b0,1'b1,1'b1,4'b1000,1'b0,4'b0000,1'b1,4'b0010,4'b0010,1'b0,4'b0010,1'b0);
    set_vec( 7, 1'b0,1'b1,1'b1,4'b0001,1'b0,4'b1110,1'b1,4'b0001,4'b0010,1'b0,4'b0001,1'b1);
    set_vec( 8, 1'b0,1'b1,1'b1,4'b1100,1'b0,4'b1111,1'b1,4'b1100,4'b0001,1'b0,4'b1100,1'b1);
    set_vec( 9, 1'b0,1'b1,1'b1,4'b0101,1'b0,4'b1011,1'b1,4'b0101,4'b1100,1'b1,4'b0101,1'b1);
    set_vec(10, 1'b0,1'b0,1'b1,4'b1111,1'b0,4'b0000,1'b1,4'b0101,4'b0101,1'b0,4'b0101,1'b0);
    set_vec(11, 1'b0,1'b0,1'b1,4'b1111,1'b1,4'b0000,1'b1,4'b0101,4'b0101,1'b0,4'b0101,1'b0);
    set_vec(12, 1'b0,1'b1,1'b1,4'b1001,1'b1,4'b0000,1'b1,4'b1001,4'b0101,1'b1,4'b1001,1'b1);
    set_vec(13, 1'b1,1'b1,1'b1,4'b0100,1'b1,4'b0000,1'b1,4'b1001,4'b1001,1'b0,4'b0000,1'b0);
    set_vec(14, 1'b0,1'b1,1'b1,4'b0100,1'b1,4'b0000,1'b1,4'b0100,4'b0000,1'b1,4'b0100,1'b1);
    set_vec(15, 1'b0,1'b0,1'b1,4'b1111,1'b0,4'b0000,1'b1,4'b0100,4'b0100,1'b0,4'b0100,1'b0);
    set_vec(16, 1'b0,1'b1,1'b1,4'b0011,1'b0,4'b0001,1'b1,4'b0011,4'b0100,1'b1,4'b0011,1'b1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; exe_valid = vecs[i].v; exe_s = vecs[i].s;
      exe_alu_flags = vecs[i].f; exe_hold = vecs[i].h; id_cond = vecs[i].cond;
      exp_q.push_back('{chk: vecs[i].chk, out_b: vecs[i].out_b, out_n: vecs[i].out_n,
                        hz: vecs[i].hz, sr: vecs[i].sr, fw: vecs[i].fw});
      #1;
      e = exp_q[0];
      if (e.chk) begin
        check("status_out_bypass", i, status_out_b, e.out_b);
        check("status_out_nobypass", i, status_out_n, e.out_n);
        check("flag_hazard_nobypass", i, {3'b000, flag_hazard_n}, {3'b000, e.hz});
        check("flag_hazard_bypass", i, {3'b000, flag_hazard_b}, 4'b0000);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("status_reg_bypass", i, status_reg_b, e.sr);
      check("status_reg_nobypass", i, status_reg_n, e.sr);
      check("flags_written_bypass", i, {3'b000, flags_written_b}, {3'b000, e.fw});
      check("flags_written_nobypass", i, {3'b000, flags_written_n}, {3'b000, e.fw});
      $display("vec %0d: rst=%b v=%b s=%b f=%b h=%b cond=%b -> sr=%b fw=%b", i, vecs[i].rst,
               vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].h, vecs[i].cond, status_reg_b, flags_written_b);
    end

    // Long stall: flags change while held, only the first held cycle may write.
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = 1'b0; exe_valid = 1'b1; exe_s = 1'b1; exe_hold = 1'b1; id_cond = 4'hE;
      exe_alu_flags = (c == 0) ? 4'b1010 : 4'b0101;
      #1;
      if (c > 0) check("held_status_out_bypass", 100 + c, status_out_b, 4'b1010);
      @(posedge clk);
      #1;
      if (flags_written_b) pulses++;
    end
    @(negedge clk);
    exe_valid = 1'b0; exe_hold = 1'b0;
    @(posedge clk);
    #1;
    if (flags_written_b) pulses++;
    check("held_write_pulses", 104, pulses[3:0], 4'd1);
    check("held_status_reg", 104, status_reg_b, 4'b1010);
    $display("hold sequence: pulses=%0d sr=%b", pulses, status_reg_b);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
